// File: rtl/sdhci_cmd_seq.sv
// sdhci_cmd_seq: SD CMD-line sequencer.
// Sends a 48-bit command frame (start, transmission, index, argument, CRC7, end),
// waits for the card's response start bit, deserialises a 48- or 136-bit response,
// checks it, then enforces an idle gap before dropping busy_o and pulsing done_o.
// Optional build macro SDHCI_CMD_RESP_CRC_EN: when defined, the receive-side CRC7
// check is built and crc_err_o follows crc_check_en_i; otherwise crc_err_o is 0.
// The transmit CRC7 is always built.
module sdhci_cmd_seq #(
  parameter int RespTimeout = 64,
  parameter int NccGap      = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         sd_tick_i,
  input  logic         abort_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  argument_i,
  input  logic [1:0]   resp_type_i,
  input  logic         crc_check_en_i,
  input  logic         index_check_en_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] response_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, GAP} state_e;

  // One shared 8-bit counter serves every state; both parameters must stay below 256.
  localparam logic [7:0] RespLast = 8'(RespTimeout - 1);
  localparam logic [7:0] GapLast  = 8'(NccGap - 1);

  // CRC7, polynomial x^7 + x^3 + 1, one bit per call, MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [39:0]    tx_sr_q, tx_sr_d;
  logic [6:0]     tx_crc_q, tx_crc_d;
  logic [5:0]     cmd_idx_q, cmd_idx_d;
  logic [1:0]     resp_type_q, resp_type_d;
  logic           idx_chk_q, idx_chk_d;
  logic [5:0]     rx_idx_q, rx_idx_d;
  logic [119:0]   resp_q, resp_d;
  logic           sd_cmd_q, sd_cmd_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;
  logic           err_to_q, err_to_d;
  logic           err_end_q, err_end_d;
  logic           err_idx_q, err_idx_d;
`ifdef SDHCI_CMD_RESP_CRC_EN
  logic [6:0]     rx_crc_q, rx_crc_d;
  logic           crc_mis_q, crc_mis_d;
  logic           crc_chk_q, crc_chk_d;
  logic           err_crc_q, err_crc_d;
  logic [7:0]     crc_top;
`else
  logic           unused_crc_check_en;
  assign unused_crc_check_en = crc_check_en_i;
`endif

  // pos is the frame bit index handled on the current tick (counter holds bits remaining).
  logic [7:0] pos;
  logic       long_resp;
  logic [7:0] payload_top;

  assign pos         = cnt_q - 8'd1;
  assign long_resp   = (resp_type_q == 2'b01);
  assign payload_top = long_resp ? 8'd127 : 8'd39;
`ifdef SDHCI_CMD_RESP_CRC_EN
  // The long response excludes start/transmission/reserved bits from its CRC.
  assign crc_top     = long_resp ? 8'd127 : 8'd46;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; every CMD-line step waits for a tick, abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (start_i) state_d = SEND;
        SEND:       if (sd_tick_i && cnt_q == 8'd1)
                      state_d = (resp_type_q == 2'b00) ? GAP : WAIT_START;
        WAIT_START: if (sd_tick_i) begin
                      if (!sd_cmd_i)                state_d = RECV;
                      else if (cnt_q == RespLast)   state_d = GAP;
                    end
        RECV:       if (sd_tick_i && cnt_q == 8'd1) state_d = GAP;
        GAP:        if (sd_tick_i && cnt_q == GapLast) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values: shifting, CRC, counters, error capture.
  always_comb begin
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    tx_crc_d    = tx_crc_q;
    cmd_idx_d   = cmd_idx_q;
    resp_type_d = resp_type_q;
    idx_chk_d   = idx_chk_q;
    rx_idx_d    = rx_idx_q;
    resp_d      = resp_q;
    sd_cmd_d    = sd_cmd_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    err_to_d    = err_to_q;
    err_end_d   = err_end_q;
    err_idx_d   = err_idx_q;
`ifdef SDHCI_CMD_RESP_CRC_EN
    rx_crc_d    = rx_crc_q;
    crc_mis_d   = crc_mis_q;
    crc_chk_d   = crc_chk_q;
    err_crc_d   = err_crc_q;
`endif
    if (abort_i) begin
      // Response register is deliberately left untouched on abort.
      cnt_d     = '0;
      sd_cmd_d  = 1'b1;
      oe_d      = 1'b0;
      err_to_d  = 1'b0;
      err_end_d = 1'b0;
      err_idx_d = 1'b0;
`ifdef SDHCI_CMD_RESP_CRC_EN
      err_crc_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            tx_sr_d     = {1'b0, 1'b1, cmd_index_i, argument_i};
            tx_crc_d    = '0;
            cmd_idx_d   = cmd_index_i;
            resp_type_d = resp_type_i;
            idx_chk_d   = index_check_en_i;
            cnt_d       = 8'd48;
            err_to_d    = 1'b0;
            err_end_d   = 1'b0;
            err_idx_d   = 1'b0;
`ifdef SDHCI_CMD_RESP_CRC_EN
            crc_chk_d   = crc_check_en_i;
            err_crc_d   = 1'b0;
`endif
          end
        end
        SEND: begin
          if (sd_tick_i) begin
            oe_d  = 1'b1;
            cnt_d = pos;
            if (cnt_q > 8'd8) begin
              sd_cmd_d = tx_sr_q[39];
              tx_sr_d  = {tx_sr_q[38:0], 1'b0};
              tx_crc_d = crc7_step(tx_crc_q, tx_sr_q[39]);
            end else if (cnt_q > 8'd1) begin
              sd_cmd_d = tx_crc_q[6];
              tx_crc_d = {tx_crc_q[5:0], 1'b0};
            end else begin
              sd_cmd_d = 1'b1;
            end
          end
        end
        WAIT_START: begin
          if (sd_tick_i) begin
            oe_d     = 1'b0;
            sd_cmd_d = 1'b1;
            if (!sd_cmd_i) begin
              cnt_d    = long_resp ? 8'd135 : 8'd47;
              resp_d   = '0;
              rx_idx_d = '0;
`ifdef SDHCI_CMD_RESP_CRC_EN
              rx_crc_d  = '0;
              crc_mis_d = 1'b0;
`endif
            end else if (cnt_q == RespLast) begin
              err_to_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        RECV: begin
          if (sd_tick_i) begin
            cnt_d = pos;
            if (pos >= 8'd8 && pos <= payload_top)
              resp_d = {resp_q[118:0], sd_cmd_i};
            if (!long_resp && pos >= 8'd40 && pos <= 8'd45)
              rx_idx_d = {rx_idx_q[4:0], sd_cmd_i};
`ifdef SDHCI_CMD_RESP_CRC_EN
            if (pos >= 8'd8 && pos <= crc_top)
              rx_crc_d = crc7_step(rx_crc_q, sd_cmd_i);
            if (pos >= 8'd1 && pos <= 8'd7) begin
              crc_mis_d = crc_mis_q | (sd_cmd_i ^ rx_crc_q[6]);
              rx_crc_d  = {rx_crc_q[5:0], 1'b0};
            end
`endif
            if (pos == 8'd0) begin
              err_end_d = ~sd_cmd_i;
              err_idx_d = idx_chk_q & ~long_resp & (rx_idx_q != cmd_idx_q);
`ifdef SDHCI_CMD_RESP_CRC_EN
              err_crc_d = crc_chk_q & crc_mis_q;
`endif
            end
          end
        end
        GAP: begin
          if (sd_tick_i) begin
            oe_d     = 1'b0;
            sd_cmd_d = 1'b1;
            if (cnt_q == GapLast) begin
              done_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset releases the CMD line immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      tx_crc_q    <= '0;
      cmd_idx_q   <= '0;
      resp_type_q <= '0;
      idx_chk_q   <= 1'b0;
      rx_idx_q    <= '0;
      resp_q      <= '0;
      sd_cmd_q    <= 1'b1;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_end_q   <= 1'b0;
      err_idx_q   <= 1'b0;
`ifdef SDHCI_CMD_RESP_CRC_EN
      rx_crc_q    <= '0;
      crc_mis_q   <= 1'b0;
      crc_chk_q   <= 1'b0;
      err_crc_q   <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      tx_crc_q    <= tx_crc_d;
      cmd_idx_q   <= cmd_idx_d;
      resp_type_q <= resp_type_d;
      idx_chk_q   <= idx_chk_d;
      rx_idx_q    <= rx_idx_d;
      resp_q      <= resp_d;
      sd_cmd_q    <= sd_cmd_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      err_to_q    <= err_to_d;
      err_end_q   <= err_end_d;
      err_idx_q   <= err_idx_d;
`ifdef SDHCI_CMD_RESP_CRC_EN
      rx_crc_q    <= rx_crc_d;
      crc_mis_q   <= crc_mis_d;
      crc_chk_q   <= crc_chk_d;
      err_crc_q   <= err_crc_d;
`endif
    end
  end

  // Error flags are only presented alongside the done pulse.
  assign sd_cmd_o      = sd_cmd_q;
  assign sd_cmd_oe_o   = oe_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign response_o    = resp_q;
  assign timeout_err_o = done_q & err_to_q;
  assign end_bit_err_o = done_q & err_end_q;
  assign index_err_o   = done_q & err_idx_q;
`ifdef SDHCI_CMD_RESP_CRC_EN
  assign crc_err_o     = done_q & err_crc_q;
`else
  assign crc_err_o     = 1'b0;
`endif

endmodule
